// File: rtl/bubble_sort_pkg.sv
// Shared types and defaults for the bubble_sort block.
//   state_e     : LOAD (capture N words), SORT (compare-swap sweeps), OUT (stream)
//   DEF_N       : default batch size
//   DEF_WIDTH   : default word width (two's-complement signed words)
package bubble_sort_pkg;
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_e;
  localparam int DEF_N     = 10;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/bubble_sort_if.sv
// Data bus of the serial sorter.
//   data_serial_i : word stream into the sorter (sampled every clk in LOAD)
//   data_serial_o : registered sorted word
//   data_valid_o  : high while data_serial_o holds a sorted word
// master = producer/consumer side (testbench), slave = sorter side.
interface bubble_sort_if
  import bubble_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic signed [WIDTH-1:0] data_serial_i;
  logic signed [WIDTH-1:0] data_serial_o;
  logic                    data_valid_o;

  modport master (output data_serial_i, input  data_serial_o, input  data_valid_o);
  modport slave  (input  data_serial_i, output data_serial_o, output data_valid_o);
endinterface

// File: rtl/bubble_sort_cmp_swap.sv
// Combinational signed compare and conditional swap of two words.
//   a_i, b_i : operands (a_i is the lower array slot)
//   lo_o     : value to write back into the lower slot
//   hi_o     : value to write back into the upper slot
// Swaps only on strict a_i > b_i, so equal words keep their order.
module cmp_swap
  import bubble_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] lo_o,
  output logic signed [WIDTH-1:0] hi_o
);
  logic swap;

  assign swap = (a_i > b_i);
  assign lo_o = swap ? b_i : a_i;
  assign hi_o = swap ? a_i : b_i;
endmodule

// File: rtl/bubble_sort.sv
// Serial-in/serial-out sorter for a batch of N signed words.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of bubble_sort_if (data_serial_i / data_serial_o / data_valid_o)
// Flow: LOAD captures N words (one per clk), SORT runs N*(N-1) fixed
// compare-swap cycles, OUT streams arr[0..N-1] then spends one edge
// dropping data_valid_o before returning straight to LOAD.
module bubble_sort
  import bubble_sort_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  bubble_sort_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_J = CW'(N - 2);

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            j_q, j_d;
  logic [CW-1:0]            pass_q, pass_d;
  logic [CW-1:0]            idx_q, idx_d;
  // Set once arr[N-1] has been driven; marks the valid-drop edge of OUT
  // without needing idx to reach N (which may not fit in CW bits).
  logic                     done_q, done_d;
  logic [N-1:0][WIDTH-1:0]  arr_q, arr_d;
  logic signed [WIDTH-1:0]  dout_q, dout_d;
  logic                     valid_q, valid_d;

  logic [CW-1:0]            j_nxt;
  logic signed [WIDTH-1:0]  cs_lo, cs_hi;

  assign j_nxt = j_q + CW'(1);

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .a_i  (arr_q[j_q]),
    .b_i  (arr_q[j_nxt]),
    .lo_o (cs_lo),
    .hi_o (cs_hi)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    done_d  = done_q;
    arr_d   = arr_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (state_q)
      LOAD: begin
        arr_d[cnt_q] = bus.data_serial_i;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          j_d     = '0;
          pass_d  = '0;
          state_d = SORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SORT: begin
        arr_d[j_q]   = cs_lo;
        arr_d[j_nxt] = cs_hi;
        if (j_q == LAST_J) begin
          j_d = '0;
          if (pass_q == LAST) begin
            idx_d   = '0;
            done_d  = 1'b0;
            state_d = OUT;
          end else begin
            pass_d = pass_q + CW'(1);
          end
        end else begin
          j_d = j_nxt;
        end
      end
      OUT: begin
        if (!done_q) begin
          dout_d  = arr_q[idx_q];
          valid_d = 1'b1;
          if (idx_q == LAST) done_d = 1'b1;
          else               idx_d  = idx_q + CW'(1);
        end else begin
          // valid drops here (default); data_serial_o holds
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      j_q     <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      arr_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      arr_q   <= arr_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_serial_o = dout_q;
  assign bus.data_valid_o  = valid_q;
endmodule

// File: tb/tb_bubble_sort.sv
module tb_bubble_sort;
  typedef logic [9:0][31:0] batch_t;
  typedef struct packed {
    batch_t din;
    batch_t exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  bubble_sort_if #(.WIDTH(32)) bus ();

  bubble_sort #(.N(10), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic batch_t pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    batch_t b;
    b[0] = a0; b[1] = a1; b[2] = a2; b[3] = a3; b[4] = a4;
    b[5] = a5; b[6] = a6; b[7] = a7; b[8] = a8; b[9] = a9;
    return b;
  endfunction

  // Reference: ascending signed sort of the batch by plain selection sort.
  function automatic batch_t model_sort(input batch_t w);
    int a[10];
    int t;
    batch_t r;
    for (int i = 0; i < 10; i++) a[i] = $signed(w[i]);
    for (int i = 0; i < 10; i++)
      for (int k = i + 1; k < 10; k++)
        if (a[k] < a[i]) begin t = a[i]; a[i] = a[k]; a[k] = t; end
    for (int i = 0; i < 10; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Drive one word per negedge; the following posedge captures it.
  task automatic feed(input batch_t w);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.data_serial_i = w[i];
    end
  endtask

  // Call right after feed: first posedge is the capture of word 9.
  task automatic collect(input batch_t exp, input string tag);
    int lat;
    bit seen;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (bus.data_valid_o) seen = 1'b1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd91);
    if (!seen) return;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      chk($sformatf("%s_valid%0d", tag, k), {31'd0, bus.data_valid_o}, 32'd1);
      chk($sformatf("%s_word%0d", tag, k), bus.data_serial_o, exp[k]);
    end
    @(posedge clk); #1;
    chk({tag, "_valid_drop"}, {31'd0, bus.data_valid_o}, 32'd0);
    chk({tag, "_hold"}, bus.data_serial_o, exp[9]);
  endtask

  vec_t   tbl[5];
  batch_t rnd;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    bus.data_serial_i = '0;

    tbl[0].din = pk(570, -750, 0, 383, -347, -881, 203, -281, 797, 345);
    tbl[0].exp = pk(-881, -750, -347, -281, 0, 203, 345, 383, 570, 797);
    tbl[1].din = pk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    tbl[1].exp = pk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    tbl[2].din = pk(10, 9, 8, 7, 6, 5, 4, 3, 2, 1);
    tbl[2].exp = pk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    tbl[3].din = pk(5, 5, -5, 0, 5, -5, 0, 0, 5, -5);
    tbl[3].exp = pk(-5, -5, -5, 0, 0, 0, 5, 5, 5, 5);
    tbl[4].din = pk(32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 0);
    tbl[4].exp = pk(32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 1, 32'h7FFFFFFF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, bus.data_valid_o}, 32'd0);
    chk("reset_dout", bus.data_serial_o, 32'd0);
    rst = 1'b1;  // released just after a posedge: next edge captures word 0

    // Directed table, batches back-to-back
    for (int t = 0; t < 5; t++) begin
      feed(tbl[t].din);
      collect(tbl[t].exp, $sformatf("vec%0d", t));
    end

    // Randomized batches checked against the reference sort
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++)
        rnd[i] = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 6)) - 32'd3;
      feed(rnd);
      collect(model_sort(rnd), $sformatf("rnd%0d", r));
    end

    // Reset in the middle of SORT
    for (int i = 0; i < 10; i++) rnd[i] = $urandom;
    feed(rnd);
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midsort_rst_valid", {31'd0, bus.data_valid_o}, 32'd0);
    chk("midsort_rst_dout", bus.data_serial_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midsort_rst_hold_valid", {31'd0, bus.data_valid_o}, 32'd0);
    rst = 1'b1;

    // Fresh batch after reset, then one immediately after its OUT phase
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) rnd[i] = $urandom;
      feed(rnd);
      collect(model_sort(rnd), $sformatf("post_rst%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
